// File: rtl/apple_collector.sv
// rtl/apple_collector.sv - apple collision tracker: per-frame hit commit, score, win and frame counter
module apple_collector (
    input  logic       clk,
    input  logic       rst,
    input  logic       update,
    input  logic [4:0] apple,
    input  logic       player,
    input  logic       restart,
    output logic [4:0] visible_apple,
    output logic [4:0] eaten,
    output logic [2:0] score,
    output logic       win,
    output logic [9:0] frames
);

    typedef enum logic [1:0] {
        PLAY   = 2'b00,
        COMMIT = 2'b01,
        WIN    = 2'b10
    } state_t;

    state_t     r_state;
    logic       r_update_q;
    logic       r_armed;
    logic [4:0] r_hit_pend;
    logic [4:0] r_eaten;
    logic [2:0] r_score;
    logic [9:0] r_frames;
    logic [4:0] r_visible;
    logic       r_win;

    logic       w_frame_edge;
    logic [4:0] w_hit_pend_next;
    logic [4:0] w_new;
    logic [2:0] w_new_cnt;

    // An edge only counts once update has been seen low after reset, so a
    // level held high through reset cannot fake a frame end.
    assign w_frame_edge    = update & ~r_update_q & r_armed;
    assign w_hit_pend_next = r_hit_pend | (apple & {5{player}} & ~r_eaten);
    assign w_new           = w_hit_pend_next & ~r_eaten;

    // Number of apples newly eaten in this commit.
    always_comb begin
        w_new_cnt = 3'd0;
        for (int i = 0; i < 5; i++) begin
            w_new_cnt = w_new_cnt + {2'b00, w_new[i]};
        end
    end

    // Game FSM with all outputs registered; restart overrides any transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= PLAY;
            r_update_q <= 1'b0;
            r_armed    <= 1'b0;
            r_hit_pend <= 5'd0;
            r_eaten    <= 5'd0;
            r_score    <= 3'd0;
            r_frames   <= 10'd0;
            r_visible  <= 5'd0;
            r_win      <= 1'b0;
        end else begin
            r_update_q <= update;
            r_armed    <= r_armed | ~update;
            r_visible  <= apple & ~r_eaten;
            if (restart) begin
                r_state    <= PLAY;
                r_hit_pend <= 5'd0;
                r_eaten    <= 5'd0;
                r_score    <= 3'd0;
                r_frames   <= 10'd0;
                r_win      <= 1'b0;
            end else begin
                case (r_state)
                    PLAY: begin
                        if (w_frame_edge) begin
                            r_eaten    <= r_eaten | w_new;
                            r_score    <= r_score + w_new_cnt;
                            r_hit_pend <= 5'd0;
                            if (r_frames != 10'd1023) begin
                                r_frames <= r_frames + 10'd1;
                            end
                            r_state    <= COMMIT;
                        end else begin
                            r_hit_pend <= w_hit_pend_next;
                        end
                    end
                    COMMIT: begin
                        r_hit_pend <= w_hit_pend_next;
                        if (r_eaten == 5'h1F) begin
                            r_state <= WIN;
                            r_win   <= 1'b1;
                        end else begin
                            r_state <= PLAY;
                        end
                    end
                    WIN: begin
                        r_win <= 1'b1;
                    end
                    default: begin
                        r_state <= PLAY;
                        r_win   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign visible_apple = r_visible;
    assign eaten         = r_eaten;
    assign score         = r_score;
    assign win           = r_win;
    assign frames        = r_frames;

endmodule

// File: tb/tb_apple_collector.sv
// tb/tb_apple_collector.sv - scoreboard bench for apple_collector against a behavioural game model
module tb_apple_collector;

    logic       clk;
    logic       rst;
    logic       update;
    logic [4:0] apple;
    logic       player;
    logic       restart;
    logic [4:0] visible_apple;
    logic [4:0] eaten;
    logic [2:0] score;
    logic       win;
    logic [9:0] frames;

    apple_collector dut (
        .clk           (clk),
        .rst           (rst),
        .update        (update),
        .apple         (apple),
        .player        (player),
        .restart       (restart),
        .visible_apple (visible_apple),
        .eaten         (eaten),
        .score         (score),
        .win           (win),
        .frames        (frames)
    );

    typedef struct packed {
        logic [4:0] vis;
        logic [4:0] eat;
        logic [2:0] scr;
        logic       won;
        logic [9:0] frm;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: the set of eaten apples, pending hits, whether the
    // game is won, whether the frame after a commit is being finalised, and
    // a plain integer frame count.
    logic [4:0] m_eaten, m_pend, m_vis;
    bit         m_won, m_commit, m_prev_upd, m_seen_low;
    int         m_frames;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t model_obs();
        obs_t o;
        o.vis = m_vis;
        o.eat = m_eaten;
        o.scr = 3'($countones(m_eaten));
        o.won = m_won;
        o.frm = 10'(m_frames);
        return o;
    endfunction

    task automatic model_reset();
        m_eaten = 0; m_pend = 0; m_vis = 0; m_won = 0; m_commit = 0;
        m_prev_upd = 0; m_seen_low = 0; m_frames = 0;
    endtask

    // What the next rising edge does with the given inputs.
    task automatic model_step(input logic [4:0] a, input bit p, input bit u, input bit r);
        bit fe;
        fe = u && !m_prev_upd && m_seen_low;
        m_prev_upd = u;
        if (!u) m_seen_low = 1;
        m_vis = a & ~m_eaten;
        if (r) begin
            m_eaten = 0; m_pend = 0; m_frames = 0; m_won = 0; m_commit = 0;
        end else if (!m_won) begin
            if (p) m_pend = m_pend | (a & ~m_eaten);
            if (m_commit) begin
                m_commit = 0;
                if (m_eaten == 5'h1F) m_won = 1;
            end else if (fe) begin
                m_eaten  = m_eaten | m_pend;
                m_pend   = 0;
                m_frames = (m_frames < 1023) ? m_frames + 1 : 1023;
                m_commit = 1;
            end
        end
    endtask

    task automatic cyc(input logic [4:0] a, input bit p, input bit u, input bit r);
        @(posedge clk);
        #2;
        apple = a; player = p; update = u; restart = r;
        model_step(a, p, u, r);
        exp_q.push_back(model_obs());
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({visible_apple, eaten, score, win, frames} !== 24'd0) begin
            errors++;
            $display("FAIL %s: vis=%b eaten=%b score=%0d win=%b frames=%0d, required all zero",
                     name, visible_apple, eaten, score, win, frames);
        end
    endtask

    // Mid-cycle asynchronous reset with update held high throughout.
    task automatic async_reset(input string name);
        @(posedge clk);
        #4;
        update = 1'b1;
        rst = 1'b1;
        #1;
        check_zero(name);
        model_reset();
        @(posedge clk);
        #4;
        rst = 1'b0;
    endtask

    // Monitor: one expected observation per clock edge, compared just after it.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{visible_apple, eaten, score, win, frames};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: vis=%b eaten=%b score=%0d win=%b frames=%0d, required vis=%b eaten=%b score=%0d win=%b frames=%0d",
                             $time, a.vis, a.eat, a.scr, a.won, a.frm, e.vis, e.eat, e.scr, e.won, e.frm);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; update = 1'b0; apple = 0; player = 0; restart = 0;
        model_reset();
        #1;
        check_zero("reset_state");
        #12;
        rst = 1'b0;

        // Apple 2 touched for 3 cycles, then a frame end.
        cyc(5'b00000, 0, 0, 0);
        repeat (3) cyc(5'b00100, 1, 0, 0);
        cyc(5'b00000, 0, 1, 0);
        cyc(5'b00100, 0, 0, 0);
        repeat (3) cyc(5'b00100, 0, 0, 0);

        // Hit on apple 0 in the same cycle as the update edge.
        cyc(5'b00001, 1, 1, 0);
        cyc(5'b00000, 0, 0, 0);
        cyc(5'b00000, 0, 0, 0);

        // Apple 3 eaten, then hit again across later frames.
        cyc(5'b01000, 1, 0, 0);
        cyc(5'b00000, 0, 1, 0);
        cyc(5'b00000, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(5'b01000, 1, 0, 0);
            cyc(5'b01000, 1, 1, 0);
            cyc(5'b01000, 1, 0, 0);
        end

        // Remaining apples: a hit during the commit cycle carries over.
        cyc(5'b00010, 1, 1, 0);
        cyc(5'b10000, 1, 0, 0);
        cyc(5'b00000, 0, 0, 0);
        cyc(5'b00000, 0, 1, 0);
        cyc(5'b00000, 0, 0, 0);
        cyc(5'b00000, 0, 0, 0);
        // Won: further updates and collisions must be ignored.
        for (int k = 0; k < 4; k++) begin
            cyc(5'b11111, 1, 1, 0);
            cyc(5'b11111, 1, 0, 0);
        end

        // Restart colliding with a frame edge that carries pending hits.
        cyc(5'b00000, 0, 0, 1);
        cyc(5'b00110, 1, 0, 0);
        cyc(5'b00110, 1, 1, 1);
        cyc(5'b00000, 0, 0, 0);
        cyc(5'b00000, 0, 0, 0);

        // Build score 4, then reset asynchronously with update held high.
        cyc(5'b01111, 1, 0, 0);
        cyc(5'b00000, 0, 1, 0);
        cyc(5'b00000, 0, 0, 0);
        cyc(5'b00000, 0, 0, 0);
        async_reset("async_reset_score4");
        repeat (4) cyc(5'b00001, 1, 1, 0);
        cyc(5'b00000, 0, 0, 0);
        cyc(5'b00001, 1, 1, 0);
        cyc(5'b00000, 0, 0, 0);
        cyc(5'b00000, 0, 0, 0);

        // Frame counter saturation with no collisions.
        cyc(5'b00000, 0, 0, 1);
        for (int k = 0; k < 1030; k++) begin
            cyc(5'b00000, 0, 1, 0);
            cyc(5'b00000, 0, 0, 0);
        end

        // Randomised play.
        for (int g = 0; g < 6; g++) begin
            cyc(5'b00000, 0, 0, 1);
            for (int k = 0; k < 300; k++) begin
                logic [4:0] ra;
                ra = ($urandom_range(0, 3) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
                cyc(ra, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 199) == 0));
            end
        end

        // Randomised reset placement.
        async_reset("async_reset_random");
        for (int k = 0; k < 50; k++) begin
            cyc(5'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d observations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
